wormhole_out_arbiter: RTL and testbench

- Router output-port stage that sits directly downstream of IN_N input flit FIFOs.
- Arbitrates round-robin among non-empty FIFOs and locks the grant for a whole wormhole packet, head through tail.
- Drives each FIFO's rd_en and forwards flits to the output link with valid/ready handshake.
- Consumes the FIFO read semantics: data appears one cycle after rd_en and is held until the next read.

---
 rtl/noc_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/wormhole_out_arbiter.sv | 128 ++++++++++++
 tb/tb_wormhole_out_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared router flit and arbiter definitions
package noc_pkg;

    // Flag positions counted down from the flit width: bit (DATA_WIDTH - offset)
    localparam int FLIT_TAIL_BIT = 1;
    localparam int FLIT_HEAD_BIT = 2;

    // Flit type as {tail, head} taken from the two top bits of a flit
    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    // Output-port arbiter states
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot picker with its own rotating pointer
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o,
    input  logic         update_i,
    input  logic [N-1:0] last_gnt_i
);

    // Pointer kept one-hot so masking and rotation need no index decode
    logic [N-1:0] ptr_q;
    logic [N-1:0] ptr_d;
    logic [N-1:0] upper_mask;
    logic [N-1:0] upper_req;

    // Prefer the lowest request at or above the pointer, else wrap to the lowest overall
    always_comb begin
        upper_mask = ~(ptr_q - N'(1));
        upper_req  = req_i & upper_mask;
        if (|upper_req) begin
            gnt_o = upper_req & (~upper_req + N'(1));
        end else begin
            gnt_o = req_i & (~req_i + N'(1));
        end
    end

    // Next pointer is the position just after the owner being released
    always_comb begin
        ptr_d = ptr_q;
        if (update_i && (|last_gnt_i)) begin
            ptr_d = {last_gnt_i[N-2:0], last_gnt_i[N-1]};
        end
    end

    // Pointer register, starts at input 0
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= N'(1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/wormhole_out_arbiter.sv
// rtl/wormhole_out_arbiter.sv - wormhole output port arbiter over IN_N FIFOs; option WORMHOLE_ARB_STATS_EN adds pkt_cnt_o
module wormhole_out_arbiter
    import noc_pkg::*;
#(
    parameter int IN_N       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID         = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [IN_N-1:0]            in_empty_i,
    input  logic [IN_N*DATA_WIDTH-1:0] in_data_i,
    output logic [IN_N-1:0]            in_rd_en_o,
    output logic [DATA_WIDTH-1:0]      out_data_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [IN_N-1:0]            grant_o,
    output logic                       busy_o
`ifdef WORMHOLE_ARB_STATS_EN
   ,output logic [15:0]                pkt_cnt_o
`endif
);

    localparam int TAIL_POS = DATA_WIDTH - FLIT_TAIL_BIT;

    if (IN_N < 2 || ID < 0) begin : g_bad_cfg
        $error("wormhole_out_arbiter: needs IN_N >= 2 and a non-negative ID");
    end

    arb_state_e            state_q;
    logic [IN_N-1:0]       grant_q;
    logic                  valid_q;
    logic [IN_N-1:0]       pick;
    logic                  read_ok;
    logic                  tail_consume;
    logic [DATA_WIDTH-1:0] or_chain [IN_N+1];

    // The FIFO read register is the holding stage, so the output is a plain one-hot mux
    assign or_chain[0] = '0;
    for (genvar k = 0; k < IN_N; k++) begin : g_mux
        assign or_chain[k+1] = or_chain[k]
                             | (in_data_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[k]}});
    end
    assign out_data_o = or_chain[IN_N];

    // Read only when the owner has data, the output slot frees up, and no tail is pending
    assign read_ok = (state_q == ARB_LOCKED)
                   & (|(grant_q & ~in_empty_i))
                   & (~valid_q | out_ready_i)
                   & ~(valid_q & out_data_o[TAIL_POS]);
    assign in_rd_en_o   = grant_q & ~in_empty_i & {IN_N{read_ok}};
    assign tail_consume = valid_q & out_ready_i & out_data_o[TAIL_POS];

    assign out_valid_o = valid_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q == ARB_LOCKED);

    rr_arbiter #(
        .N (IN_N)
    ) u_rr (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (~in_empty_i),
        .gnt_o      (pick),
        .update_i   (tail_consume),
        .last_gnt_i (grant_q)
    );

    // Grant lock FSM: pick an owner in IDLE, hold it until its tail flit leaves
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    valid_q <= 1'b0;
                    if (|(~in_empty_i)) begin
                        grant_q <= pick;
                        state_q <= ARB_LOCKED;
                    end
                end
                ARB_LOCKED: begin
                    if (read_ok) begin
                        valid_q <= 1'b1;
                    end else if (valid_q && out_ready_i) begin
                        valid_q <= 1'b0;
                    end
                    if (tail_consume) begin
                        grant_q <= '0;
                        state_q <= ARB_IDLE;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    grant_q <= '0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef WORMHOLE_ARB_STATS_EN
    logic [15:0] pkt_cnt_q;
    logic [15:0] pkt_cnt_d;

    // Saturating count of packets whose tail has left the port
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (tail_consume && (pkt_cnt_q != 16'hFFFF)) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
    end

    // Packet counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_wormhole_out_arbiter.sv
// tb/tb_wormhole_out_arbiter.sv - scoreboard bench for wormhole_out_arbiter
module tb_wormhole_out_arbiter;
    import noc_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;

    typedef logic [DW-1:0] flit_t;
    typedef struct {
        int    k;
        flit_t f;
    } load_t;
    typedef struct {
        flit_t         d;
        logic [N-1:0]  g;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_i;
    logic [N-1:0]    in_empty = '1;
    logic [N*DW-1:0] in_data = '0;
    logic [N-1:0]    rd_en;
    flit_t           out_data;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    grant;
    logic            busy;
`ifdef WORMHOLE_ARB_STATS_EN
    logic [15:0]     pkt_cnt;
`endif

    int    n_vec  = 0;
    int    n_fail = 0;
    flit_t fifo_q [N][$];
    load_t load_q [$];
    exp_t  exp_q  [$];

    always #5 clk = ~clk;

    wormhole_out_arbiter #(
        .IN_N       (N),
        .DATA_WIDTH (DW),
        .ID         (0)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_empty_i  (in_empty),
        .in_data_i   (in_data),
        .in_rd_en_o  (rd_en),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .grant_o     (grant),
        .busy_o      (busy)
`ifdef WORMHOLE_ARB_STATS_EN
       ,.pkt_cnt_o   (pkt_cnt)
`endif
    );

    // Upstream FIFO model: data register updates one edge after rd_en; flushed with the router reset
    always @(posedge clk) begin
        if (rst_i) begin
            for (int k = 0; k < N; k++) fifo_q[k].delete();
            load_q.delete();
            in_empty <= '1;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (rd_en[k] && fifo_q[k].size() > 0) in_data[k*DW +: DW] <= fifo_q[k].pop_front();
            end
            while (load_q.size() > 0) begin
                load_t ld;
                ld = load_q.pop_front();
                fifo_q[ld.k].push_back(ld.f);
            end
            for (int k = 0; k < N; k++) in_empty[k] <= (fifo_q[k].size() == 0);
        end
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    function automatic flit_t mk(flit_type_e t, int k, int p);
        logic [1:0] kb;
        logic [3:0] pb;
        kb = 2'(k);
        pb = 4'(p);
        return {t, kb, pb};
    endfunction

    task automatic load(int k, flit_t f);
        load_t ld;
        ld.k = k;
        ld.f = f;
        load_q.push_back(ld);
    endtask

    task automatic expect_flit(flit_t f, int k);
        exp_t e;
        e.d = f;
        e.g = 4'b0001 << k;
        exp_q.push_back(e);
    endtask

    // Load a whole packet into input k and queue it as the next expected output
    task automatic pkt(int k, int len, int tag);
        flit_type_e t;
        flit_t f;
        for (int j = 0; j < len; j++) begin
            if (len == 1) t = FLIT_SINGLE;
            else if (j == 0) t = FLIT_HEAD;
            else if (j == len - 1) t = FLIT_TAIL;
            else t = FLIT_BODY;
            f = mk(t, k, (tag << 2) | j);
            load(k, f);
            expect_flit(f, k);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && !busy && (&in_empty) && load_q.size() == 0) done = 1'b1;
        end
        n_vec++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_drain: %0d flits still expected, busy=%0b, expected all delivered and idle",
                     name, exp_q.size(), busy);
        end
        @(negedge clk);
    endtask

    // Scoreboard and protocol monitor, sampled after the falling edge
    task automatic monitor();
        flit_t prev_d;
        bit    prev_stall;
        exp_t  e;
        prev_stall = 1'b0;
        prev_d     = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_i) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_data", 32'(out_data), 32'(prev_d));
                    check("stall_valid", 32'(out_valid), 32'(1));
                end
                prev_stall = out_valid && !out_ready;
                prev_d     = out_data;
                if (rd_en != '0) begin
                    check("rd_onehot", 32'($countones(rd_en)), 32'(1));
                    check("rd_nonempty", 32'(rd_en & in_empty), 32'(0));
                    check("rd_owner", 32'(rd_en & ~grant), 32'(0));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_flit: got %0h, expected no flit", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("flit_data", 32'(out_data), 32'(e.d));
                        check("flit_grant", 32'(grant), 32'(e.g));
                    end
                end
            end
        end
    endtask

    task automatic check_idle_outputs(string name);
        check({name, "_grant"}, 32'(grant), 32'(0));
        check({name, "_valid"}, 32'(out_valid), 32'(0));
        check({name, "_rd"}, 32'(rd_en), 32'(0));
        check({name, "_busy"}, 32'(busy), 32'(0));
        check({name, "_data"}, 32'(out_data), 32'(0));
    endtask

    initial begin
`ifdef WORMHOLE_ARB_STATS_EN
        logic [15:0] cnt_before;
`endif
        rst_i     = 1'b1;
        out_ready = 1'b1;
        fork
            monitor();
            begin
                #200000;
                n_fail++;
                $display("FAIL watchdog: bench still running, expected completion");
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
                $finish;
            end
        join_none

        #3;
        check_idle_outputs("reset");
`ifdef WORMHOLE_ARB_STATS_EN
        check("reset_pkt_cnt", 32'(pkt_cnt), 32'(0));
`endif
        cyc(2);
        rst_i = 1'b0;

        // Only input 2 holds H,B,B,T: grant at cycle 1, flits cycles 2..5, released at cycle 6
        pkt(2, 4, 0);
        cyc(1); #1;
        check("t1_c0_grant", 32'(grant), 32'(0));
        check("t1_c0_rd", 32'(rd_en), 32'(0));
        cyc(1); #1;
        check("t1_c1_grant", 32'(grant), 32'(4'b0100));
        check("t1_c1_rd", 32'(rd_en), 32'(4'b0100));
        check("t1_c1_valid", 32'(out_valid), 32'(0));
        check("t1_c1_busy", 32'(busy), 32'(1));
        cyc(1); #1;
        check("t1_c2_valid", 32'(out_valid), 32'(1));
        cyc(4); #1;
        check("t1_c6_grant", 32'(grant), 32'(0));
        check("t1_c6_busy", 32'(busy), 32'(0));
        drain("t1");

        // Pointer now 3: inputs 1 and 3 ready together, 3 wins first
        pkt(3, 1, 1);
        pkt(1, 1, 1);
        cyc(2); #1;
        check("ptr3_grant", 32'(grant), 32'(4'b1000));
        drain("ptr3");

        // Two-flit packets on 0 and 1: input 0 whole, one bubble, then input 1
        pkt(0, 2, 2);
        pkt(1, 2, 2);
        cyc(2); #1;
        check("t2_c1_grant", 32'(grant), 32'(4'b0001));
        cyc(3); #1;
        check("t2_bubble_grant", 32'(grant), 32'(0));
        cyc(1); #1;
        check("t2_c5_grant", 32'(grant), 32'(4'b0010));
        drain("t2");

        // Backpressure for three cycles while the first body flit is on the output
        pkt(2, 4, 3);
        cyc(4);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_rd", 32'(rd_en), 32'(0));
            check("bp_valid", 32'(out_valid), 32'(1));
            check("bp_data", 32'(out_data), 32'(mk(FLIT_BODY, 2, (3 << 2) | 1)));
            cyc(1);
        end
        out_ready = 1'b1;
        drain("bp");

        // Asynchronous reset after the head flit of an input 2 packet
        load(2, mk(FLIT_HEAD, 2, 8));
        load(2, mk(FLIT_BODY, 2, 9));
        load(2, mk(FLIT_BODY, 2, 10));
        load(2, mk(FLIT_TAIL, 2, 11));
        expect_flit(mk(FLIT_HEAD, 2, 8), 2);
        cyc(4);
        #1;
        rst_i = 1'b1;
        #1;
        check_idle_outputs("async_rst");
`ifdef WORMHOLE_ARB_STATS_EN
        check("async_rst_pkt_cnt", 32'(pkt_cnt), 32'(0));
`endif
        check("async_rst_exp_left", 32'(exp_q.size()), 32'(0));
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        pkt(1, 1, 4);
        pkt(3, 1, 4);
        cyc(2); #1;
        check("rst_ptr0_grant", 32'(grant), 32'(4'b0010));
        drain("rst");

        // Owner empties after its head flit and refills later while input 3 waits
        load(0, mk(FLIT_HEAD, 0, 5));
        expect_flit(mk(FLIT_HEAD, 0, 5), 0);
        expect_flit(mk(FLIT_BODY, 0, 6), 0);
        expect_flit(mk(FLIT_TAIL, 0, 7), 0);
        expect_flit(mk(FLIT_SINGLE, 3, 5), 3);
        cyc(2); #1;
        check("gap_c1_grant", 32'(grant), 32'(4'b0001));
        load(3, mk(FLIT_SINGLE, 3, 5));
        cyc(1); #1;
        check("gap_c2_valid", 32'(out_valid), 32'(1));
        for (int i = 0; i < 3; i++) begin
            cyc(1); #1;
            check("gap_hold_grant", 32'(grant), 32'(4'b0001));
            check("gap_hold_valid", 32'(out_valid), 32'(0));
            check("gap_hold_rd", 32'(rd_en), 32'(0));
        end
        load(0, mk(FLIT_BODY, 0, 6));
        load(0, mk(FLIT_TAIL, 0, 7));
        cyc(5); #1;
        check("gap_c10_grant", 32'(grant), 32'(4'b1000));
        drain("gap");

        // Single-flit packets on all inputs, served 0,1,2,3
`ifdef WORMHOLE_ARB_STATS_EN
        cnt_before = pkt_cnt;
`endif
        for (int k = 0; k < N; k++) pkt(k, 1, 6);
        drain("single");
`ifdef WORMHOLE_ARB_STATS_EN
        check("single_pkt_cnt_delta", 32'(pkt_cnt - cnt_before), 32'(4));
        check("total_pkt_cnt", 32'(pkt_cnt), 32'(8));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
